regfile_window_ctrl: RTL and testbench

- Sequences all accesses to the single-port, 72-register windowed register file (4 windows, one shared port).
- Accepts one operand/result transaction at a time from the control unit: reads rs1 and rs2 in two cycles, hands the operands to the ALU, waits for the result, then writes rd.
- Owns the current window pointer (CWP) and the window invalid mask (WIM), applies SAVE/RESTORE window changes, and raises window overflow/underflow traps instead of corrupting windows.

---
 rtl/regfile_ctrl_pkg.sv | 29 ++
 rtl/cwp_unit.sv | 29 ++
 rtl/regfile_window_ctrl.sv | 151 +++++++++++++++
 tb/tb_regfile_window_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared encodings for the windowed register file controller
package regfile_ctrl_pkg;

  localparam int NWIN  = 4;
  localparam int CWP_W = 2;

  typedef enum logic [1:0] {
    OP_ALU     = 2'b00,
    OP_SAVE    = 2'b01,
    OP_RESTORE = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'b00,
    TRAP_OVF  = 2'b01,
    TRAP_UNF  = 2'b10
  } trap_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WAIT,
    ST_WR,
    ST_TRAP
  } state_e;

endpackage

// File: rtl/cwp_unit.sv
// rtl/cwp_unit.sv - next-window computation and window trap detection
module cwp_unit
  import regfile_ctrl_pkg::*;
(
  input  logic [CWP_W-1:0] cwp,
  input  logic [1:0]       op,
  input  logic [NWIN-1:0]  wim,
  output logic [CWP_W-1:0] new_cwp,
  output logic             trap_req,
  output logic [1:0]       trap_code
);

  always_comb begin
    new_cwp   = cwp;
    trap_req  = 1'b0;
    trap_code = TRAP_NONE;
    case (op)
      OP_SAVE:    new_cwp = cwp - CWP_W'(1);
      OP_RESTORE: new_cwp = cwp + CWP_W'(1);
      default:    new_cwp = cwp;
    endcase
    // Entering a window marked invalid traps instead of moving there
    if ((op == OP_SAVE || op == OP_RESTORE) && wim[new_cwp]) begin
      trap_req  = 1'b1;
      trap_code = (op == OP_SAVE) ? TRAP_OVF : TRAP_UNF;
    end
  end

endmodule

// File: rtl/regfile_window_ctrl.sv
// rtl/regfile_window_ctrl.sv - sequences read/read/write transactions on the shared
// windowed register file port and owns CWP/WIM
module regfile_window_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NWIN   = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  output logic              busy,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] result,
  input  logic              result_valid,
  output logic              trap,
  output logic [1:0]        trap_type,
  input  logic              wim_we,
  input  logic [NWIN-1:0]   wim_in,
  output logic [1:0]        cwp,
  output logic [NWIN-1:0]   wim,
  output logic              rf_enable,
  output logic              rf_rw,
  output logic [4:0]        rf_r_num,
  output logic [1:0]        rf_window,
  output logic [DATA_W-1:0] rf_in,
  input  logic [DATA_W-1:0] rf_out
);

  state_e     state;
  logic [1:0] op_q;
  logic [4:0] rs2_q;
  logic [4:0] rd_q;
  logic [1:0] new_cwp_q;

  logic [1:0] new_cwp;
  logic       trap_req;
  logic [1:0] trap_code;

  cwp_unit u_cwp_unit (
    .cwp       (cwp),
    .op        (op),
    .wim       (wim),
    .new_cwp   (new_cwp),
    .trap_req  (trap_req),
    .trap_code (trap_code)
  );

  // Outputs are registered: each transition loads the port values of the state being entered
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      new_cwp_q <= '0;
      busy      <= 1'b0;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      trap      <= 1'b0;
      trap_type <= TRAP_NONE;
      cwp       <= '0;
      wim       <= '0;
      rf_enable <= 1'b0;
      rf_rw     <= 1'b0;
      rf_r_num  <= '0;
      rf_window <= '0;
      rf_in     <= '0;
    end else begin
      if (wim_we) wim <= wim_in;
      trap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q      <= op;
            rs2_q     <= rs2;
            rd_q      <= rd;
            new_cwp_q <= new_cwp;
            busy      <= 1'b1;
            if (trap_req) begin
              state     <= ST_TRAP;
              trap      <= 1'b1;
              trap_type <= trap_code;
            end else begin
              state     <= ST_RD_A;
              rf_enable <= 1'b1;
              rf_rw     <= 1'b0;
              rf_r_num  <= rs1;
              rf_window <= cwp;
            end
          end
        end
        ST_RD_A: begin
          op_a     <= rf_out;
          rf_r_num <= rs2_q;
          state    <= ST_RD_B;
        end
        ST_RD_B: begin
          op_b      <= rf_out;
          rf_enable <= 1'b0;
          rf_r_num  <= '0;
          rf_window <= '0;
          op_valid  <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (result_valid) begin
            op_valid <= 1'b0;
            if (op_q == OP_READ) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              // The write lands in the new window; rd=0 spends the cycle without a write
              rf_in     <= result;
              rf_rw     <= 1'b1;
              rf_enable <= (rd_q != 5'd0);
              rf_r_num  <= rd_q;
              rf_window <= (rd_q != 5'd0) ? new_cwp_q : 2'd0;
              state     <= ST_WR;
            end
          end
        end
        ST_WR: begin
          cwp       <= new_cwp_q;
          rf_enable <= 1'b0;
          rf_rw     <= 1'b0;
          rf_r_num  <= '0;
          rf_window <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_TRAP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_window_ctrl.sv
// tb/tb_regfile_window_ctrl.sv - scoreboard bench for regfile_window_ctrl against a
// 72-register windowed register file model
module tb_regfile_window_ctrl;
  import regfile_ctrl_pkg::*;

  logic        Clk = 1'b0;
  logic        Clr, req, result_valid, wim_we;
  logic [1:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] result;
  logic [3:0]  wim_in;
  logic        busy, op_valid, trap, rf_enable, rf_rw;
  logic [31:0] op_a, op_b, rf_in, rf_out;
  logic [1:0]  trap_type, cwp, rf_window;
  logic [3:0]  wim;
  logic [4:0]  rf_r_num;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_cwp = 2'd0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  regfile_window_ctrl #(.DATA_W(32), .NWIN(4)) dut (
    .Clk(Clk), .Clr(Clr), .req(req), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .result(result), .result_valid(result_valid), .trap(trap), .trap_type(trap_type),
    .wim_we(wim_we), .wim_in(wim_in), .cwp(cwp), .wim(wim),
    .rf_enable(rf_enable), .rf_rw(rf_rw), .rf_r_num(rf_r_num), .rf_window(rf_window),
    .rf_in(rf_in), .rf_out(rf_out)
  );

  // Windowed file: 8 globals, then 4x16 rotating regs; ins of window w alias outs of w+1
  logic [31:0] phys [0:71];
  logic        model_clear = 1'b1;

  function automatic int pidx(input logic [4:0] k, input logic [1:0] w);
    if (k < 5'd8) return int'(k);
    return 8 + ((int'(w) * 16 + int'(k) - 8) % 64);
  endfunction

  assign rf_out = phys[pidx(rf_r_num, rf_window)];

  always @(posedge Clk) begin
    if (model_clear) begin
      for (int i = 0; i < 72; i++) phys[i] <= '0;
    end else if (rf_enable && rf_rw) begin
      phys[pidx(rf_r_num, rf_window)] <= rf_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_wim(input logic [3:0] v);
    wim_we = 1'b1;
    wim_in = v;
    step();
    wim_we = 1'b0;
    check("wim_write", wim, v);
  endtask

  task automatic run_txn(input logic [1:0] t_op, input logic [4:0] t_rs1, input logic [4:0] t_rs2,
                         input logic [4:0] t_rd, input logic [31:0] t_res,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] ecwp);
    exp_t e;
    sb.push_back('{a: ea, b: eb});
    req = 1'b1; op = t_op; rs1 = t_rs1; rs2 = t_rs2; rd = t_rd;
    step();
    req = 1'b0;
    check("rd_a_busy", busy, 1);
    check("rd_a_en", rf_enable, 1);
    check("rd_a_rw", rf_rw, 0);
    check("rd_a_num", rf_r_num, t_rs1);
    check("rd_a_win", rf_window, exp_cwp);
    step();
    check("rd_b_num", rf_r_num, t_rs2);
    check("rd_b_win", rf_window, exp_cwp);
    step();
    check("wait_op_valid", op_valid, 1);
    check("wait_rf_en", rf_enable, 0);
    if (op_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check("op_a", op_a, e.a);
      check("op_b", op_b, e.b);
    end
    result = t_res; result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    if (t_op != OP_READ) begin
      check("wr_rw", rf_rw, 1);
      check("wr_en", rf_enable, (t_rd != 5'd0));
      check("wr_num", rf_r_num, t_rd);
      check("wr_win", rf_window, (t_rd != 5'd0) ? ecwp : 2'd0);
      check("wr_data", rf_in, t_res);
      check("wr_cwp_old", cwp, exp_cwp);
      step();
    end
    exp_cwp = ecwp;
    check("idle_busy", busy, 0);
    check("idle_op_valid", op_valid, 0);
    check("idle_cwp", cwp, exp_cwp);
  endtask

  task automatic run_trap(input logic [1:0] t_op, input logic [1:0] etype);
    req = 1'b1; op = t_op; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    step();
    req = 1'b0;
    check("trap_pulse", trap, 1);
    check("trap_type", trap_type, etype);
    check("trap_busy", busy, 1);
    check("trap_rf_en", rf_enable, 0);
    step();
    check("trap_end", trap, 0);
    check("trap_idle_busy", busy, 0);
    check("trap_rf_en_after", rf_enable, 0);
    check("trap_cwp", cwp, exp_cwp);
    check("trap_type_held", trap_type, etype);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] vals [4];
    Clr = 1'b1; req = 1'b0; op = OP_ALU; rs1 = '0; rs2 = '0; rd = '0;
    result = '0; result_valid = 1'b0; wim_we = 1'b0; wim_in = '0;
    step();
    step();
    model_clear = 1'b0;
    Clr = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_cwp", cwp, 0);
    check("rst_wim", wim, 0);
    check("rst_trap_type", trap_type, 0);
    check("rst_rf_en", rf_enable, 0);
    check("rst_op_a", op_a, 0);

    run_txn(OP_ALU, 5'd0, 5'd0, 5'd1, 32'hDEADBEEF, 32'h0, 32'h0, 2'd0);
    run_txn(OP_READ, 5'd1, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 2'd0);
    run_txn(OP_ALU, 5'd0, 5'd0, 5'd8, 32'h1234, 32'h0, 32'h0, 2'd0);
    run_txn(OP_SAVE, 5'd1, 5'd8, 5'd16, 32'h55, 32'hDEADBEEF, 32'h1234, 2'd3);
    run_txn(OP_READ, 5'd16, 5'd24, 5'd0, 32'h0, 32'h55, 32'h1234, 2'd3);
    run_txn(OP_RESTORE, 5'd16, 5'd24, 5'd0, 32'h77, 32'h55, 32'h1234, 2'd0);

    write_wim(4'b1000);
    run_trap(OP_SAVE, TRAP_OVF);

    write_wim(4'b0000);
    run_txn(OP_SAVE, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd3);
    write_wim(4'b0001);
    run_trap(OP_RESTORE, TRAP_UNF);

    // Reset lands in WAIT alongside a WIM write and a request; Clr must win
    req = 1'b1; op = OP_ALU; rs1 = 5'd1; rs2 = 5'd0; rd = 5'd5;
    step();
    req = 1'b0;
    step();
    step();
    check("mid_wait", op_valid, 1);
    Clr = 1'b1; wim_we = 1'b1; wim_in = 4'hF; req = 1'b1;
    result = 32'hABCD; result_valid = 1'b1;
    step();
    Clr = 1'b0; wim_we = 1'b0; req = 1'b0; result_valid = 1'b0;
    exp_cwp = 2'd0;
    check("clr_busy", busy, 0);
    check("clr_op_valid", op_valid, 0);
    check("clr_cwp", cwp, 0);
    check("clr_wim", wim, 0);
    check("clr_trap_type", trap_type, 0);
    check("clr_rf_en", rf_enable, 0);
    check("clr_op_a", op_a, 0);
    step();
    check("clr_no_accept", busy, 0);
    check("clr_no_write", rf_enable, 0);

    run_txn(OP_READ, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'hDEADBEEF, 2'd0);

    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      run_txn(OP_ALU, 5'd0, 5'd0, 5'(2 + i), vals[i], 32'h0, 32'h0, 2'd0);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(OP_READ, 5'(2 + i), 5'd1, 5'd0, 32'h0, vals[i], 32'hDEADBEEF, 2'd0);
    end

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
